// File: rtl/noc_params.sv
// Shared NoC router parameters and the port identifier type used by the
// allocator and its neighbours.
package noc_params;

   localparam int VC_NUM    = 4;
   localparam int VC_SIZE   = $clog2(VC_NUM);
   localparam int PORT_SIZE = 3;

   typedef enum logic [PORT_SIZE-1:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      EAST  = 3'd4
   } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter: priority search starts at the pointer, and the
// pointer moves past the winner only when the caller confirms the grant.
module round_robin_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  request,
   input  logic          update_en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr;
   logic          found;

   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && request[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (update_en && found) begin
         ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Two-stage separable switch allocator (input VC arbitration, then output
// arbitration). Optional per-output grant counters under SA_GRANT_COUNT_EN.
module switch_allocator
   import noc_params::*;
#(
   parameter int PORT_NUM = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0] switch_request_i,
   input  port_t                         out_port_i      [PORT_NUM][VC_NUM],
   input  logic [VC_SIZE-1:0]            downstream_vc_i [PORT_NUM][VC_NUM],
   input  logic [PORT_NUM-1:0][VC_NUM-1:0] on_off_i,
   output logic [PORT_NUM-1:0]           valid_sel_o,
   output logic [VC_SIZE-1:0]            vc_sel_o        [PORT_NUM],
   output logic [PORT_SIZE-1:0]          xb_sel_o        [PORT_NUM],
`ifdef SA_GRANT_COUNT_EN
   output logic [PORT_NUM-1:0]           valid_flit_o,
   output logic [15:0]                   grant_count_o   [PORT_NUM]
`else
   output logic [PORT_NUM-1:0]           valid_flit_o
`endif
);

   localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int OW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   logic [VC_NUM-1:0]    eligible [PORT_NUM];
   logic [VC_NUM-1:0]    vc_gnt   [PORT_NUM];
   logic [VW-1:0]        vc_idx   [PORT_NUM];
   logic [PORT_NUM-1:0]  has_req;
   logic [PORT_SIZE-1:0] tgt      [PORT_NUM];
   logic [PORT_NUM-1:0]  out_req  [PORT_NUM];
   logic [PORT_NUM-1:0]  out_gnt  [PORT_NUM];
   logic [OW-1:0]        out_idx  [PORT_NUM];
   logic [PORT_NUM-1:0]  out_any;
   logic [PORT_NUM-1:0]  in_grant;
   logic [PORT_SIZE-1:0] xb_sel_p1 [PORT_NUM];
   logic [PORT_NUM-1:0]  vld_p1;

   always_comb begin
      for (int i = 0; i < PORT_NUM; i++) begin
         eligible[i] = '0;
         for (int v = 0; v < VC_NUM; v++)
            eligible[i][v] = switch_request_i[i][v] &&
                             on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
      end
   end

   // Stage 1: one VC per input port
   for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
      round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
         .clk       (clk),
         .rst       (rst),
         .request   (eligible[i]),
         .update_en (valid_sel_o[i]),
         .grant     (vc_gnt[i]),
         .grant_idx (vc_idx[i])
      );
      assign has_req[i]  = |vc_gnt[i];
      assign tgt[i]      = out_port_i[i][vc_idx[i]];
      assign vc_sel_o[i] = valid_sel_o[i] ? VC_SIZE'(vc_idx[i]) : '0;
   end

   always_comb begin
      for (int o = 0; o < PORT_NUM; o++) begin
         out_req[o] = '0;
         for (int i = 0; i < PORT_NUM; i++)
            out_req[o][i] = has_req[i] && (tgt[i] == PORT_SIZE'(o));
      end
   end

   // Stage 2: one input per output port
   for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
      round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
         .clk       (clk),
         .rst       (rst),
         .request   (out_req[o]),
         .update_en (|out_req[o]),
         .grant     (out_gnt[o]),
         .grant_idx (out_idx[o])
      );
      assign out_any[o]  = |out_gnt[o];
      assign xb_sel_o[o] = xb_sel_p1[o];
   end

   always_comb begin
      in_grant = '0;
      for (int o = 0; o < PORT_NUM; o++)
         for (int i = 0; i < PORT_NUM; i++)
            in_grant[i] = in_grant[i] | out_gnt[o][i];
   end

   assign valid_sel_o  = rst ? '0 : in_grant;
   assign valid_flit_o = vld_p1;

   // p1: crossbar select lines up with the buffer read of the granted flit
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= '0;
         for (int o = 0; o < PORT_NUM; o++) xb_sel_p1[o] <= '0;
      end else begin
         vld_p1 <= out_any;
         for (int o = 0; o < PORT_NUM; o++)
            if (out_any[o]) xb_sel_p1[o] <= PORT_SIZE'(out_idx[o]);
      end
   end

`ifdef SA_GRANT_COUNT_EN
   always_ff @(posedge clk) begin
      for (int o = 0; o < PORT_NUM; o++) begin
         if (rst)
            grant_count_o[o] <= '0;
         else if (out_any[o] && grant_count_o[o] != 16'hFFFF)
            grant_count_o[o] <= grant_count_o[o] + 16'd1;
      end
   end
`endif

endmodule
